controle_varredura: RTL and testbench
=====================================

# controle_varredura

Scan controller for the 4-digit seven-segment display. It owns the digit-multiplex timing: a prescaled slot counter, per-slot blanking dead time against ghosting, and per-digit blink. It also double-buffers the four segment patterns so the upstream timer/state logic can update them without tearing. It sits between the display-content logic and the display pins, driving `digito` and `segmentos` directly.

## Interface
- `DIV`, 8, clock cycles per digit slot; legal range ≥2.
- `BLANK`, 2, dead cycles at the start of each slot; legal range 0 ≤ BLANK < DIV.
- `BLINK_FRAMES`, 4, full frames per blink half-period; legal range ≥1.

- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  display on; low forces dark and resets the scan.
- `seg0_in`..`seg3_in`  in  7 each  segment patterns for digits 0..3, active-high.
- `upd_req`  in  1  level request to load `seg*_in` into the shadow registers.
- `upd_ack`  out  1  one-cycle pulse; the load has been performed.
- `blink_mask`  in  4  bit i set = digit i blinks.
- `digito`  out  4  one-hot digit enable, active-high; all-zero when dark.
- `segmentos`  out  7  segment drive for the enabled digit, active-high.
- `scan_idx`  out  2  index of the current slot (0..3).
- `frame_start`  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- FSM states:
  - OFF: `enable`=0.
  - GAP: blanking portion of a slot.
  - SHOW: visible portion of a slot.
- Transitions:
  - OFF→GAP when `enable`=1; goes straight to SHOW if BLANK=0.
  - GAP→SHOW when the slot counter reaches BLANK.
  - SHOW→GAP (next slot) when the slot counter reaches DIV-1.
  - Any state→OFF when `enable`=0.
- Slot counter runs 0..DIV-1, then wraps and increments `scan_idx` mod 4. Slot order is 0,1,2,3,0…
- Outputs per state:
  - GAP and OFF: `digito`=0, `segmentos`=0.
  - SHOW: `digito`=1<<scan_idx, `segmentos`=shadow[scan_idx].
  - Blink-off phase with `blink_mask[scan_idx]`=1: `digito`=0 and `segmentos`=0 for the whole slot. Slot timing is unchanged.
- Blink:
  - Frame counter increments at every wrap 3→0.
  - After BLINK_FRAMES frames, the blink phase toggles and the frame counter clears.
  - Phase starts "on" (visible).
  - OFF clears the frame counter and sets phase to "on".
- Update handshake:
  - Requester holds `upd_req` and `seg*_in` stable until `upd_ack`.
  - While enabled, the load happens only on a frame boundary: the cycle where slot 3's counter = DIV-1 and `upd_req`=1. All four shadows load together on that edge and `upd_ack` pulses for one cycle.
  - In OFF, the load happens on the first edge with `upd_req`=1.
  - `upd_ack` never pulses on two consecutive cycles. After an ack, at least one cycle with `upd_req`=0 is required before the next request is honoured. An edge detector on `upd_req` blocks re-load while it stays high.
- Simultaneous events:
  - `enable` falling on the same edge as a boundary load: load completes, ack pulses, state goes OFF.
  - `blink_mask` changes take effect on the next cycle, even mid-slot.

## Timing
- Reset (async assert, sync deassert handled upstream) gives:
  - state OFF, `digito`=0, `segmentos`=0, `scan_idx`=0, `frame_start`=0, `upd_ack`=0.
  - shadows all 0, blink phase "on", all counters 0.
- All outputs are registered, with no combinational path from inputs to outputs.
- First cycle after `enable` rises: state GAP (or SHOW if BLANK=0), `scan_idx`=0, `frame_start`=1.
- Frame period is 4·DIV cycles. `frame_start` repeats every 4·DIV cycles.
- Data loaded on a boundary is visible from the SHOW portion of the immediately following slot 0.
- Worst-case request latency:
  - Enabled: 4·DIV cycles from `upd_req` rising to `upd_ack`.
  - OFF: 1 cycle.
- Counter widths are sized from parameters ($clog2). No wrap occurs other than those defined above.

## Test plan
- Reset/idle: assert `reset_n`=0 mid-SHOW → next sampled outputs: `digito`=0, `segmentos`=0, `scan_idx`=0; after release with `enable`=0, outputs stay 0.
- Scan sequence (DIV=8, BLANK=2, shadows 7'h01/02/04/08), `enable`=1 → each 8-cycle slot shows `digito`=0 for 2 cycles, then 6 cycles of 4'b0001/0010/0100/1000 with the matching segments; `frame_start` every 32 cycles.
- Update: raise `upd_req` with new patterns at slot 1 → `upd_ack` on the last cycle of slot 3, one cycle wide; old data displayed until then, new data on the next slot 0 SHOW; holding `upd_req` high gives no second ack.
- Update while OFF: `enable`=0, `upd_req`=1 → `upd_ack` the next cycle; on enable, the first SHOW shows the new data.
- Blink (BLINK_FRAMES=2, `blink_mask`=4'b0100) → digit 2 is dark in frames 2–3 and visible in frames 0–1 and 4–5; other digits are unaffected.
- Enable drop mid-slot 2 → next cycle all dark; re-enable restarts at slot 0 with `frame_start`=1 and blink phase "on".

Source files
------------

// File: rtl/controle_varredura_if.sv
// Segment-pattern update bus between the display-content logic and the scan controller.
interface controle_varredura_if;
  logic [6:0] seg0_in;
  logic [6:0] seg1_in;
  logic [6:0] seg2_in;
  logic [6:0] seg3_in;
  logic       upd_req;
  logic       upd_ack;

  modport master (output seg0_in, seg1_in, seg2_in, seg3_in, upd_req, input upd_ack);
  modport slave  (input  seg0_in, seg1_in, seg2_in, seg3_in, upd_req, output upd_ack);
endinterface

// File: rtl/controle_varredura.sv
// 4-digit seven-segment scan controller: slot multiplexing with dead time,
// per-digit blink and tear-free double-buffered segment patterns.
module controle_varredura #(
  parameter int unsigned DIV          = 8,
  parameter int unsigned BLANK        = 2,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  controle_varredura_if.slave    upd,
  input  logic [3:0]             blink_mask,
  output logic [3:0]             digito,
  output logic [6:0]             segmentos,
  output logic [1:0]             scan_idx,
  output logic                   frame_start
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
  localparam logic [FW-1:0] FLAST   = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {OFF, GAP, SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          blink_on, blink_on_n;
  logic          armed, armed_n;
  logic          ack_q, ack_n;
  logic [6:0]    shadow   [4];
  logic [6:0]    shadow_n [4];
  logic          ld, ld_off, bnd, vis;
  logic [3:0]    digito_n;
  logic [6:0]    segmentos_n;
  logic          frame_start_n;

  assign upd.upd_ack = ack_q;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = scan_idx;
    fcnt_n     = fcnt;
    blink_on_n = blink_on;
    shadow_n   = shadow;

    bnd    = (state != OFF) && (cnt == LAST) && (scan_idx == 2'd3);
    ld_off = (state == OFF) && upd.upd_req && armed;
    // The boundary ack is raised one edge early so it sits on slot 3's last
    // cycle; the shadows themselves load on the edge that ends that cycle.
    ld     = ld_off || (ack_q && bnd);
    if (ld) begin
      shadow_n[0] = upd.seg0_in;
      shadow_n[1] = upd.seg1_in;
      shadow_n[2] = upd.seg2_in;
      shadow_n[3] = upd.seg3_in;
    end

    if (!enable) begin
      state_n    = OFF;
      cnt_n      = '0;
      idx_n      = '0;
      fcnt_n     = '0;
      blink_on_n = 1'b1;
    end else if (state == OFF) begin
      cnt_n   = '0;
      idx_n   = '0;
      state_n = (BLANK == 0) ? SHOW : GAP;
    end else begin
      if (cnt == LAST) begin
        cnt_n = '0;
        idx_n = scan_idx + 2'd1;
        if (scan_idx == 2'd3) begin
          if (fcnt == FLAST) begin
            fcnt_n     = '0;
            blink_on_n = ~blink_on;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
      state_n = (cnt_n < BLANK_C) ? GAP : SHOW;
    end

    ack_n = ld_off ||
            ((state_n != OFF) && (idx_n == 2'd3) && (cnt_n == LAST) && upd.upd_req && armed);

    if (!upd.upd_req)
      armed_n = 1'b1;
    else if (ack_n)
      armed_n = 1'b0;
    else
      armed_n = armed;

    vis           = (state_n == SHOW) && (blink_on_n || !blink_mask[idx_n]);
    digito_n      = vis ? (4'b0001 << idx_n) : '0;
    segmentos_n   = vis ? shadow_n[idx_n] : '0;
    frame_start_n = (state_n != OFF) && (cnt_n == '0) && (idx_n == 2'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OFF;
      cnt         <= '0;
      scan_idx    <= '0;
      fcnt        <= '0;
      blink_on    <= 1'b1;
      armed       <= 1'b1;
      ack_q       <= 1'b0;
      shadow      <= '{default: '0};
      digito      <= '0;
      segmentos   <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      scan_idx    <= idx_n;
      fcnt        <= fcnt_n;
      blink_on    <= blink_on_n;
      armed       <= armed_n;
      ack_q       <= ack_n;
      shadow      <= shadow_n;
      digito      <= digito_n;
      segmentos   <= segmentos_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura (DIV=8, BLANK=2, BLINK_FRAMES=2).
module tb_controle_varredura;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] blink_mask;
  logic [3:0] digito;
  logic [6:0] segmentos;
  logic [1:0] scan_idx;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  logic [6:0] old_p [4] = '{7'h01, 7'h02, 7'h04, 7'h08};
  logic [6:0] new_p [4] = '{7'h11, 7'h22, 7'h44, 7'h70};

  controle_varredura_if upd ();

  controle_varredura #(.DIV(8), .BLANK(2), .BLINK_FRAMES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .upd         (upd),
    .blink_mask  (blink_mask),
    .digito      (digito),
    .segmentos   (segmentos),
    .scan_idx    (scan_idx),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " digito"}, 32'(digito), 32'h0);
    chk({tag, " segmentos"}, 32'(segmentos), 32'h0);
    chk({tag, " scan_idx"}, 32'(scan_idx), 32'h0);
  endtask

  initial begin
    int slot, c, frame;
    bit vis, blink_off;
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;

    reset_n = 1'b0;
    enable = 1'b0;
    blink_mask = 4'b0000;
    upd.upd_req = 1'b0;
    upd.seg0_in = '0; upd.seg1_in = '0; upd.seg2_in = '0; upd.seg3_in = '0;

    repeat (2) @(negedge clock);
    chk_dark("reset");
    chk("reset frame_start", 32'(frame_start), 32'h0);
    chk("reset upd_ack", 32'(upd.upd_ack), 32'h0);

    // Load while OFF: ack on the very next cycle
    reset_n = 1'b1;
    @(negedge clock);
    upd.seg0_in = old_p[0]; upd.seg1_in = old_p[1];
    upd.seg2_in = old_p[2]; upd.seg3_in = old_p[3];
    upd.upd_req = 1'b1;
    @(negedge clock);
    chk("off ack high", 32'(upd.upd_ack), 32'h1);
    upd.upd_req = 1'b0;
    @(negedge clock);
    chk("off ack low", 32'(upd.upd_ack), 32'h0);
    chk_dark("off idle");

    blink_mask = 4'b0100;
    enable = 1'b1;

    // Seven frames of scanning with a boundary update and digit-2 blink
    for (int n = 0; n <= 211; n++) begin
      @(negedge clock);
      slot = (n / 8) % 4;
      c = n % 8;
      frame = n / 32;
      blink_off = ((frame / 2) % 2) == 1;
      vis = (c >= 2) && !(slot == 2 && blink_off);
      exp_dig = vis ? 4'(1 << slot) : 4'h0;
      exp_seg = vis ? ((frame >= 2) ? new_p[slot] : old_p[slot]) : 7'h0;
      chk($sformatf("scan n=%0d digito", n), 32'(digito), 32'(exp_dig));
      chk($sformatf("scan n=%0d segmentos", n), 32'(segmentos), 32'(exp_seg));
      chk($sformatf("scan n=%0d scan_idx", n), 32'(scan_idx), 32'(slot));
      chk($sformatf("scan n=%0d frame_start", n), 32'(frame_start), 32'(n % 32 == 0));
      chk($sformatf("scan n=%0d upd_ack", n), 32'(upd.upd_ack), 32'(n == 63));
      if (n == 40) begin
        upd.seg0_in = new_p[0]; upd.seg1_in = new_p[1];
        upd.seg2_in = new_p[2]; upd.seg3_in = new_p[3];
        upd.upd_req = 1'b1;
      end
      if (n == 130) upd.upd_req = 1'b0;
      if (n == 211) enable = 1'b0;
    end

    @(negedge clock);
    chk_dark("enable drop");
    chk("enable drop frame_start", 32'(frame_start), 32'h0);
    enable = 1'b1;

    // Re-enable: restart at slot 0, blink phase back to visible
    for (int m = 0; m <= 34; m++) begin
      @(negedge clock);
      slot = (m / 8) % 4;
      c = m % 8;
      exp_dig = (c >= 2) ? 4'(1 << slot) : 4'h0;
      exp_seg = (c >= 2) ? new_p[slot] : 7'h0;
      chk($sformatf("reen m=%0d digito", m), 32'(digito), 32'(exp_dig));
      chk($sformatf("reen m=%0d segmentos", m), 32'(segmentos), 32'(exp_seg));
      chk($sformatf("reen m=%0d scan_idx", m), 32'(scan_idx), 32'(slot));
      chk($sformatf("reen m=%0d frame_start", m), 32'(frame_start), 32'(m % 32 == 0));
    end

    // Asynchronous reset in the middle of a SHOW cycle
    reset_n = 1'b0;
    #1;
    chk_dark("async reset");
    @(negedge clock);
    enable = 1'b0;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk_dark("post reset idle");
    end

    // Shadows were cleared by reset: first SHOW lights digit 0 with no segments
    enable = 1'b1;
    repeat (3) @(negedge clock);
    chk("cleared shadow digito", 32'(digito), 32'h1);
    chk("cleared shadow segmentos", 32'(segmentos), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
